// File: rtl/axis_pkt_fifo_pkg.sv
// Shared AXI-Stream constants and packet-FSM state encodings.
// Also consumed by the UART framer.
package axis_pkt_fifo_pkg;

   localparam int AXIS_DATA_W = 8;
   localparam int AXIS_DEPTH  = 16;

   typedef enum logic {
      ST_STORE = 1'b0,
      ST_CUT   = 1'b1
   } pkt_state_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// The array is intentionally not reset.
module axis_fifo_ram #(
   parameter int W      = 9,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [W-1:0]      wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [W-1:0]      rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with first-word-fall-through output, level/threshold flags
// and optional store-and-forward packet mode with oversize-packet cut-through.
module axis_pkt_fifo
   import axis_pkt_fifo_pkg::*;
#(
   parameter int DATA_W    = AXIS_DATA_W,
   parameter int DEPTH     = AXIS_DEPTH,
   parameter int PKT_MODE  = 0,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          s_tdata,
   input  logic                       s_tlast,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   output logic [DATA_W-1:0]          m_tdata,
   output logic                       m_tlast,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [$clog2(DEPTH):0]     level,
   output logic [$clog2(DEPTH):0]     pkt_count,
   output logic                       almost_full,
   output logic                       almost_empty
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   level_q, pkt_q;
   logic [DATA_W:0]   head;
   logic              head_vld, push, pop, cnt_inc, cnt_dec;
   pkt_state_t        state, state_nx;

   axis_fifo_ram #(.W(DATA_W + 1), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata ({s_tlast, s_tdata}),
      .raddr (rd_ptr),
      .rdata (head)
   );

   // s_tready looks only at registered level, so a full FIFO refuses a push
   // even when a pop happens in the same cycle.
   assign s_tready = (level_q != FULL_LVL);
   assign push     = s_tvalid && s_tready;
   assign pop      = head_vld && m_tready;
   assign cnt_inc  = push && s_tlast;
   assign cnt_dec  = pop && head[DATA_W];

   always_comb begin
      state_nx = state;
      head_vld = (level_q != '0);
      if (PKT_MODE != 0) begin
         case (state)
            ST_STORE: begin
               head_vld = (level_q != '0) && (pkt_q != '0);
               // Full with no complete packet: only forwarding can make room.
               if (level_q == FULL_LVL && pkt_q == '0) state_nx = ST_CUT;
            end
            ST_CUT: begin
               if (head_vld && m_tready && head[DATA_W]) state_nx = ST_STORE;
            end
            default: state_nx = ST_STORE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_STORE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         pkt_q   <= '0;
      end else begin
         state <= state_nx;
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   level_q <= level_q + CNT_ONE;
            2'b01:   level_q <= level_q - CNT_ONE;
            default: level_q <= level_q;
         endcase
         case ({cnt_inc, cnt_dec})
            2'b10:   pkt_q <= pkt_q + CNT_ONE;
            2'b01:   pkt_q <= pkt_q - CNT_ONE;
            default: pkt_q <= pkt_q;
         endcase
      end
   end

   assign m_tvalid     = head_vld;
   assign m_tdata      = head_vld ? head[DATA_W-1:0] : '0;
   assign m_tlast      = head_vld && head[DATA_W];
   assign level        = level_q;
   assign pkt_count    = pkt_q;
   assign almost_full  = (int'(level_q) >= AFULL_TH);
   assign almost_empty = (int'(level_q) <= AEMPTY_TH);

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench: stream DEPTH=4, packet DEPTH=8 and packet DEPTH=4 instances
// share one input stimulus; each phase resets and checks one instance.
module tb_axis_pkt_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_tdata = '0;
   logic       s_tlast = 1'b0;
   logic       s_tvalid = 1'b0;
   logic       m_tready = 1'b0;

   logic       s_s_tready, s_m_tlast, s_m_tvalid, s_afull, s_aempty;
   logic [7:0] s_m_tdata;
   logic [2:0] s_level, s_pkt;
   logic       p8_s_tready, p8_m_tlast, p8_m_tvalid, p8_afull, p8_aempty;
   logic [7:0] p8_m_tdata;
   logic [3:0] p8_level, p8_pkt;
   logic       p4_s_tready, p4_m_tlast, p4_m_tvalid, p4_afull, p4_aempty;
   logic [7:0] p4_m_tdata;
   logic [2:0] p4_level, p4_pkt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axis_pkt_fifo #(.DATA_W(8), .DEPTH(4), .PKT_MODE(0)) u_s (
      .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
      .s_tready(s_s_tready), .m_tdata(s_m_tdata), .m_tlast(s_m_tlast), .m_tvalid(s_m_tvalid),
      .m_tready(m_tready), .level(s_level), .pkt_count(s_pkt),
      .almost_full(s_afull), .almost_empty(s_aempty));

   axis_pkt_fifo #(.DATA_W(8), .DEPTH(8), .PKT_MODE(1)) u_p8 (
      .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
      .s_tready(p8_s_tready), .m_tdata(p8_m_tdata), .m_tlast(p8_m_tlast), .m_tvalid(p8_m_tvalid),
      .m_tready(m_tready), .level(p8_level), .pkt_count(p8_pkt),
      .almost_full(p8_afull), .almost_empty(p8_aempty));

   axis_pkt_fifo #(.DATA_W(8), .DEPTH(4), .PKT_MODE(1)) u_p4 (
      .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
      .s_tready(p4_s_tready), .m_tdata(p4_m_tdata), .m_tlast(p4_m_tlast), .m_tvalid(p4_m_tvalid),
      .m_tready(m_tready), .level(p4_level), .pkt_count(p4_pkt),
      .almost_full(p4_afull), .almost_empty(p4_aempty));

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0; s_tdata = '0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic push(input int d, input bit last);
      s_tvalid = 1'b1; s_tdata = 8'(d); s_tlast = last;
      step();
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wi, ri, first, steps;

      // reset state
      do_reset();
      chk("rst_s_tready", int'(s_s_tready), 1);
      chk("rst_m_tvalid", int'(s_m_tvalid), 0);
      chk("rst_m_tdata",  int'(s_m_tdata), 0);
      chk("rst_m_tlast",  int'(s_m_tlast), 0);
      chk("rst_level",    int'(s_level), 0);
      chk("rst_aempty",   int'(s_aempty), 1);
      chk("rst_afull",    int'(s_afull), 0);

      // stream: fill, refused push, drain
      push('hA1, 1'b0);
      chk("s_vld_lat1", int'(s_m_tvalid), 1);
      chk("s_afull_l1", int'(s_afull), 0);
      push('hA2, 1'b0); push('hA3, 1'b0); push('hA4, 1'b0);
      chk("s_full_lvl", int'(s_level), 4);
      chk("s_full_rdy", int'(s_s_tready), 0);
      chk("s_full_af",  int'(s_afull), 1);
      chk("s_full_ae",  int'(s_aempty), 0);
      push('hA5, 1'b0);
      chk("s_refuse_lvl", int'(s_level), 4);
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("s_drain_vld",  int'(s_m_tvalid), 1);
         chk("s_drain_data", int'(s_m_tdata), 'hA1 + i);
         step();
      end
      m_tready = 1'b0;
      chk("s_empty_lvl", int'(s_level), 0);
      chk("s_empty_vld", int'(s_m_tvalid), 0);

      // stream: simultaneous push/pop at level 2, pointers wrap
      do_reset();
      push(0, 1'b0); push(1, 1'b0);
      wi = 2; ri = 0;
      s_tvalid = 1'b1; m_tready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s_tdata = 8'(wi);
         chk("s_pp_data", int'(s_m_tdata), ri);
         step();
         wi++; ri++;
      end
      s_tvalid = 1'b0; m_tready = 1'b0;
      chk("s_pp_lvl", int'(s_level), 2);
      chk("s_pp_head", int'(s_m_tdata), 20);

      // packet DEPTH=8: store until tlast
      do_reset();
      push('h10, 1'b0);
      chk("p8_hold0", int'(p8_m_tvalid), 0);
      push('h11, 1'b0);
      chk("p8_hold1", int'(p8_m_tvalid), 0);
      chk("p8_pkt0",  int'(p8_pkt), 0);
      push('h12, 1'b1);
      chk("p8_vld",  int'(p8_m_tvalid), 1);
      chk("p8_pkt1", int'(p8_pkt), 1);
      chk("p8_lvl3", int'(p8_level), 3);
      m_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("p8_data", int'(p8_m_tdata), 'h10 + i);
         chk("p8_last", int'(p8_m_tlast), int'(i == 2));
         step();
      end
      m_tready = 1'b0;
      chk("p8_pkt_end", int'(p8_pkt), 0);
      chk("p8_vld_end", int'(p8_m_tvalid), 0);

      // packet DEPTH=4: oversize packet forces cut-through
      do_reset();
      m_tready = 1'b1;
      wi = 0; ri = 0; first = -1; steps = 0;
      for (int t = 0; t < 40 && ri < 6; t++) begin
         s_tvalid = (wi < 6);
         s_tdata  = 8'(32'h20 + wi);
         s_tlast  = (wi == 5);
         if (steps == 4) begin
            chk("p4_full_lvl", int'(p4_level), 4);
            chk("p4_full_pkt", int'(p4_pkt), 0);
            chk("p4_full_vld", int'(p4_m_tvalid), 0);
         end
         if (p4_m_tvalid) begin
            if (first < 0) first = steps;
            chk("p4_data", int'(p4_m_tdata), 'h20 + ri);
            chk("p4_last", int'(p4_m_tlast), int'(ri == 5));
            ri++;
         end
         if (s_tvalid && p4_s_tready) wi++;
         step();
         steps++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
      chk("p4_delivered", ri, 6);
      chk("p4_first_vld", first, 5);
      chk("p4_end_lvl", int'(p4_level), 0);
      chk("p4_end_pkt", int'(p4_pkt), 0);
      push('h40, 1'b0);
      chk("p4_back_store", int'(p4_m_tvalid), 0);

      // full + pop + push same cycle: pop wins, push refused
      do_reset();
      push('hB1, 1'b0); push('hB2, 1'b0); push('hB3, 1'b0); push('hB4, 1'b0);
      s_tvalid = 1'b1; s_tdata = 8'hB5; m_tready = 1'b1;
      step();
      s_tvalid = 1'b0;
      chk("s_fpp_lvl", int'(s_level), 3);
      chk("s_fpp_rdy", int'(s_s_tready), 1);
      for (int i = 0; i < 3; i++) begin
         chk("s_fpp_data", int'(s_m_tdata), 'hB2 + i);
         step();
      end
      m_tready = 1'b0;
      chk("s_fpp_empty", int'(s_level), 0);

      // async reset mid-packet
      do_reset();
      push('h50, 1'b0); push('h51, 1'b0); push('h52, 1'b0);
      chk("mid_s_lvl", int'(s_level), 3);
      chk("mid_s_vld", int'(s_m_tvalid), 1);
      chk("mid_p8_lvl", int'(p8_level), 3);
      rst = 1'b1;
      #1;
      chk("arst_s_vld",  int'(s_m_tvalid), 0);
      chk("arst_s_lvl",  int'(s_level), 0);
      chk("arst_s_rdy",  int'(s_s_tready), 1);
      chk("arst_p8_lvl", int'(p8_level), 0);
      step();
      rst = 1'b0;
      push('h30, 1'b0);
      chk("post_hold", int'(p8_m_tvalid), 0);
      push('h31, 1'b1);
      chk("post_vld", int'(p8_m_tvalid), 1);
      chk("post_lvl", int'(p8_level), 2);
      chk("post_pkt", int'(p8_pkt), 1);
      m_tready = 1'b1;
      chk("post_d0", int'(p8_m_tdata), 'h30);
      chk("post_l0", int'(p8_m_tlast), 0);
      step();
      chk("post_d1", int'(p8_m_tdata), 'h31);
      chk("post_l1", int'(p8_m_tlast), 1);
      step();
      m_tready = 1'b0;
      chk("post_end_lvl", int'(p8_level), 0);
      chk("post_end_pkt", int'(p8_pkt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Parametrised synchronous AXI-Stream FIFO, the successor to the plain byte FIFO in the UART datapath. It buffers a byte or word stream between the AXIS slave (RX/host side) and the AXIS master (TX/consumer side) using standard valid/ready handshakes and first-word-fall-through output. It adds level reporting, programmable almost-full/almost-empty flags and an optional packet (store-and-forward) mode. In packet mode, a packet longer than the FIFO cannot deadlock it.

## Interface
Parameters:
- DATA_W, 8: tdata width in bits (≥1).
- DEPTH, 16: entries; power of two, ≥2. ADDR_W = $clog2(DEPTH).
- PKT_MODE, 0: 0 = stream mode; 1 = store-and-forward on tlast boundaries.
- AFULL_TH, DEPTH-2: almost_full asserted when level ≥ AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserted when level ≤ AEMPTY_TH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_tdata  in  DATA_W  write data.
- s_tlast  in  1  end-of-packet marker, stored per entry.
- s_tvalid  in  1  write request.
- s_tready  out  1  FIFO can accept; = (level != DEPTH).
- m_tdata  out  DATA_W  head entry data; forced 0 when m_tvalid=0.
- m_tlast  out  1  head entry tlast; forced 0 when m_tvalid=0.
- m_tvalid  out  1  head entry available to consumer.
- m_tready  in  1  consumer accepts.
- level  out  ADDR_W+1  entries stored, 0..DEPTH.
- pkt_count  out  ADDR_W+1  complete packets (tlast beats) stored.
- almost_full, almost_empty  out  1  threshold flags.

## Operation
- Push: s_tvalid && s_tready at a rising edge. Writes {s_tlast, s_tdata} at wr_ptr; wr_ptr increments, wrapping mod DEPTH.
- Pop: m_tvalid && m_tready at a rising edge. rd_ptr increments, wrapping mod DEPTH.
- level: +1 on push only, −1 on pop only, unchanged on both or neither.
- pkt_count: +1 on a push with s_tlast=1, −1 on a pop with m_tlast=1, unchanged if both occur in the same cycle.
- s_tready depends only on registered level, never on m_tready. A push is refused when full, even if a pop happens in the same cycle.
- Stream mode (PKT_MODE=0): m_tvalid = (level != 0).
- Packet mode (PKT_MODE=1) uses a two-state FSM:
  - STORE: m_tvalid = (level != 0) && (pkt_count != 0).
  - STORE→CUT when level == DEPTH && pkt_count == 0, i.e. an oversize packet would otherwise deadlock.
  - CUT: m_tvalid = (level != 0). Output continues even when the FIFO is no longer full.
  - CUT→STORE on a pop with m_tlast=1.
- Reset values: level=0, pkt_count=0, pointers=0, FSM=STORE. Outputs: s_tready=1, m_tvalid=0, m_tdata=0, m_tlast=0, almost_empty=1, almost_full=0 (given AFULL_TH>0).
- Reset mid-packet discards all contents; no partial packet survives.
- Storage array is not reset.

## Timing
- Latency from a push to m_tvalid:
  - Stream mode: 1 cycle.
  - Packet mode: 1 cycle after the push of the tlast beat.
- Read is first-word-fall-through: m_tdata/m_tlast are combinational from mem[rd_ptr] and valid in the same cycle m_tvalid is high.
- Throughput: one push and one pop per cycle sustained while 0 < level < DEPTH.
- m_tvalid, once high, stays high until the pop. The exception is reset.
- s_tready falls in the cycle after the push that makes level == DEPTH. It rises in the cycle after the first pop.
- CUT entry is registered: m_tvalid rises 1 cycle after level reaches DEPTH with pkt_count = 0.
- Flags and level are registered-derived; they update the cycle after the push/pop.

## Structure
- The shared package holds only the AXIS-related constants and the FSM state encodings ST_STORE and ST_CUT. Both are also used by the future UART framer.
- ADDR_W is derived locally.
- One natural sub-module: axis_fifo_ram, a simple dual-port array (one synchronous write port, one asynchronous read port) of width DATA_W+1.

## Test plan
- Stream mode, DATA_W=8, DEPTH=4: push 0xA1..0xA4 with m_tready=0 → level=4, s_tready=0, almost_full=1. Push 0xA5 attempted → refused. Then drain → outputs A1,A2,A3,A4 in order, level returns to 0.
- Simultaneous push/pop at level=2 for 20 cycles with m_tready=1 → level stays 2. Data is in order and pointers wrap past DEPTH without loss.
- Packet mode, DEPTH=8: push 3 beats 0x10,0x11,0x12 (tlast on 0x12) → m_tvalid stays 0 until the cycle after 0x12, then pkt_count=1. Pop all 3 → pkt_count=0.
- Packet mode, DEPTH=4: push a 6-beat packet with m_tready=1 → after 4 beats full with pkt_count=0, FSM enters CUT and m_tvalid rises next cycle. All 6 beats delivered, then FSM returns to STORE.
- Full FIFO, m_tready=1 and s_tvalid=1 in the same cycle → the pop occurs, the push is refused, level=DEPTH−1.
- Assert rst mid-packet with level=3 → same-cycle m_tvalid=0, level=0, s_tready=1. After release, a new packet passes correctly.
